piezo_sequencer: RTL and testbench
==================================

// Module: piezo_sequencer
// PURPOSE
//  Programmable single-voice tone sequencer driving a piezo speaker.
//  - Holds a writable step table of per-step phase increments (0 = rest).
//  - Plays the table at a fixed tempo through a phase-accumulator oscillator (NCO).
//  - Adds start/stop control, a runtime length, loop mode and an end-of-tune pulse.
//  - Sits between game logic (sound-effect and theme triggers) and the speaker pin.
// PARAMETERS
//  ACC_W    21       NCO accumulator width; speaker is accumulator MSB. f_out = f_clk*inc/2^ACC_W
//  INC_W    9        width of one phase increment (table entry)
//  DEPTH    128      number of steps in table
//  ADDR_W   $clog2(DEPTH)  step address width (derived)
//  TICK_DIV 4194304  clocks per step (tempo); must be >=2
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  start     in   1         1-cycle pulse: begin playback at step 0 (ignored while busy)
//  stop      in   1         1-cycle pulse: abort playback
//  loop_en   in   1         1: wrap to step 0 after last step; sampled at each end-of-tune
//  len       in   ADDR_W+1  number of steps to play (0..DEPTH); sampled at start
//  wr_en     in   1         table write strobe
//  wr_addr   in   ADDR_W    table write address
//  wr_inc    in   INC_W     table write data (phase increment)
//  busy      out  1         playback active
//  step_idx  out  ADDR_W    currently playing step
//  done      out  1         1-cycle pulse on natural end of tune (not on stop)
//  speaker   out  1         square-wave output
// BEHAVIOUR
//  - Reset: busy=0, done=0, step_idx=0, speaker=0; accumulator, tick counter, cur_inc, len_q=0.
//    Table RAM is not reset.
//  - FSM IDLE/PLAY.
//  - IDLE + start & !stop & len!=0 -> PLAY next cycle, with:
//    step_idx=0, tick=0, acc=0, cur_inc=mem[0], len_q=len.
//  - IDLE + start & len==0 -> stay IDLE, done=1 for the next cycle.
//  - start & stop in the same cycle: stop wins, nothing starts.
//  - start while PLAY: ignored.
//  - PLAY tempo: tick counts 0..TICK_DIV-1, so each step lasts exactly TICK_DIV clocks.
//    At tick==TICK_DIV-1:
//    - if step_idx != len_q-1: step_idx+1, cur_inc=mem[step_idx+1];
//    - else if loop_en: step_idx=0, cur_inc=mem[0];
//    - else: ->IDLE, busy=0, done=1 for one cycle, cur_inc=0.
//  - stop in PLAY -> IDLE next cycle: busy=0, speaker=0, step_idx=0, no done.
//  - NCO:
//    - in PLAY with cur_inc!=0: acc <= acc + cur_inc, truncated mod 2^ACC_W (wraps silently);
//    - cur_inc==0 (rest) or IDLE: acc holds.
//    - acc resets to 0 on start and on every step change.
//  - speaker = acc[ACC_W-1] & busy & (cur_inc!=0), registered.
//  - Table: combinational read, synchronous write (wr_en), allowed in any state.
//    A write to the playing step takes effect only when that step is next loaded.
//  - Reset asserted mid-play: all outputs return to reset values immediately, without waiting for a clock edge.
// STRUCTURE
//  - Package piezo_pkg:
//    - note increments NOTE_REST=0, NOTE_F=17, NOTE_GS=20, NOTE_A=21, NOTE_CH=25, NOTE_EH=31, NOTE_FH=33;
//    - state enum {ST_IDLE, ST_PLAY}.
//  - Sub-module piezo_nco (ACC_W, INC_W): clk, rst_n, en, clr, inc -> msb.
//  - Table RAM, tempo counter and FSM stay in piezo_sequencer.
// TESTING (bench uses TICK_DIV=4, ACC_W=4, DEPTH=8)
//  1 Reset: release rst_n -> busy=0, done=0, step_idx=0, speaker=0; held until start.
//  2 Write mem[0..2]={2,0,3}, len=3, loop_en=0, pulse start:
//    - busy=1 next cycle;
//    - step_idx 0,1,2 each held 4 clocks;
//    - done=1 exactly one cycle after 12 PLAY clocks, then busy=0.
//  3 Rest: during step 1 (inc 0) speaker=0 for all 4 clocks and acc unchanged.
//  4 NCO: TICK_DIV=64, mem[0]=1 -> speaker period 16 clocks (8 high/8 low); mem[0]=4 -> period 4.
//  5 Loop/stop:
//    - loop_en=1, len=2 -> step_idx 0,1,0,1..., no done;
//    - stop mid-step -> busy=0, speaker=0 next cycle, no done.
//  6 Corners:
//    - start&stop same cycle -> stays IDLE;
//    - len=0 start -> one done pulse, busy stays 0;
//    - rst_n low mid-play -> outputs 0 asynchronously.

Source files
------------

// File: rtl/piezo_pkg.sv
// Shared constants and types for the piezo tone sequencer.
// Note increments assume the default 21-bit accumulator.
package piezo_pkg;

    localparam logic [8:0] NOTE_REST = 9'd0;
    localparam logic [8:0] NOTE_F    = 9'd17;
    localparam logic [8:0] NOTE_GS   = 9'd20;
    localparam logic [8:0] NOTE_A    = 9'd21;
    localparam logic [8:0] NOTE_CH   = 9'd25;
    localparam logic [8:0] NOTE_EH   = 9'd31;
    localparam logic [8:0] NOTE_FH   = 9'd33;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // Counter width for a modulus of n (at least one bit)
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piezo_nco.sv
// Phase-accumulator oscillator; the square wave is the accumulator MSB.
// Sum is formed wide enough for either operand, then truncated (silent wrap).
module piezo_nco
    import piezo_pkg::*;
#(
    parameter int ACC_W = 21,
    parameter int INC_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic             msb
);

    localparam int SW = (ACC_W > INC_W) ? ACC_W : INC_W;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [SW-1:0]    sum;

    // Next phase: clear wins over advance, otherwise hold
    always_comb begin
        sum   = SW'(acc_q) + SW'(inc);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    // Phase accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign msb = acc_q[ACC_W-1];

endmodule

// File: rtl/piezo_sequencer.sv
// Single-voice step sequencer: writable increment table, fixed tempo,
// loop/stop control and an end-of-tune pulse, driving a piezo pin.
module piezo_sequencer
    import piezo_pkg::*;
#(
    parameter int ACC_W    = 21,
    parameter int INC_W    = 9,
    parameter int DEPTH    = 128,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int TICK_DIV = 4194304
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   len,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INC_W-1:0]  wr_inc,
    output logic              busy,
    output logic [ADDR_W-1:0] step_idx,
    output logic              done,
    output logic              speaker
);

    localparam int TW = cnt_w(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [INC_W-1:0]  mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [INC_W-1:0]  cur_q, cur_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] step_nxt;
    logic              last_step;
    logic              tick_end;
    logic              nco_clr;
    logic              nco_en;
    logic              nco_msb;

    assign step_nxt  = step_q + 1'b1;
    assign last_step = ({1'b0, step_q} == (len_q - 1'b1));
    assign tick_end  = (tick_q == TICK_LAST);

    // Step table write port; no reset so it maps to plain RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_inc;
        end
    end

    // Playback control: start/stop, tempo counting and step advance
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tick_d  = tick_q;
        cur_d   = cur_q;
        len_d   = len_q;
        done_d  = 1'b0;
        nco_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (len != '0) begin
                        state_d = ST_PLAY;
                        step_d  = '0;
                        tick_d  = '0;
                        cur_d   = mem_q[0];
                        len_d   = len;
                        nco_clr = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    tick_d  = '0;
                    cur_d   = '0;
                end else if (tick_end) begin
                    tick_d  = '0;
                    nco_clr = 1'b1;
                    if (!last_step) begin
                        step_d = step_nxt;
                        cur_d  = mem_q[step_nxt];
                    end else if (loop_en) begin
                        step_d = '0;
                        cur_d  = mem_q[0];
                    end else begin
                        state_d = ST_IDLE;
                        step_d  = '0;
                        cur_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            tick_q  <= '0;
            cur_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            cur_q   <= cur_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign nco_en = (state_q == ST_PLAY) && (cur_q != '0);

    piezo_nco #(
        .ACC_W (ACC_W),
        .INC_W (INC_W)
    ) u_nco (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (nco_en),
        .clr   (nco_clr),
        .inc   (cur_q),
        .msb   (nco_msb)
    );

    // Pin is a gate of flop outputs only, so it drops with busy or a rest
    assign busy     = (state_q == ST_PLAY);
    assign step_idx = step_q;
    assign done     = done_q;
    assign speaker  = nco_msb & busy & (cur_q != '0);

endmodule

// File: tb/tb_piezo_sequencer.sv
// Scoreboard bench: stimulus queues the expected outputs for each clock,
// a monitor pops and compares one entry per clock just after the edge.
module tb_piezo_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, stop_a, loop_a, wr_a;
    logic [3:0] len_a;
    logic [2:0] wa_a;
    logic [8:0] wi_a;
    logic       busy_a, done_a, spk_a;
    logic [2:0] step_a;

    logic       start_b, stop_b, loop_b, wr_b;
    logic [3:0] len_b;
    logic [2:0] wa_b;
    logic [8:0] wi_b;
    logic       busy_b, done_b, spk_b;
    logic [2:0] step_b;

    piezo_sequencer #(
        .ACC_W    (4),
        .DEPTH    (8),
        .TICK_DIV (4)
    ) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .stop     (stop_a),
        .loop_en  (loop_a),
        .len      (len_a),
        .wr_en    (wr_a),
        .wr_addr  (wa_a),
        .wr_inc   (wi_a),
        .busy     (busy_a),
        .step_idx (step_a),
        .done     (done_a),
        .speaker  (spk_a)
    );

    piezo_sequencer #(
        .ACC_W    (4),
        .DEPTH    (8),
        .TICK_DIV (64)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .stop     (stop_b),
        .loop_en  (loop_b),
        .len      (len_b),
        .wr_en    (wr_b),
        .wr_addr  (wa_b),
        .wr_inc   (wi_b),
        .busy     (busy_b),
        .step_idx (step_b),
        .done     (done_b),
        .speaker  (spk_b)
    );

    typedef struct {
        bit       ca;
        bit       busy;
        bit       done;
        bit [2:0] step;
        bit       spk;
        bit       cb;
        bit       spkb;
        string    tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t ea(input string t, input bit b, input bit d,
                                input bit [2:0] s, input bit sp);
        exp_t e;
        e.ca   = 1'b1;
        e.busy = b;
        e.done = d;
        e.step = s;
        e.spk  = sp;
        e.cb   = 1'b0;
        e.spkb = 1'b0;
        e.tag  = t;
        return e;
    endfunction

    function automatic exp_t eb(input string t, input bit sp);
        exp_t e;
        e.ca   = 1'b0;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.step = 3'd0;
        e.spk  = 1'b0;
        e.cb   = 1'b1;
        e.spkb = sp;
        e.tag  = t;
        return e;
    endfunction

    // Queue the response for the coming edge, then clear one-shot strobes
    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        stop_a  = 1'b0;
        wr_a    = 1'b0;
        start_b = 1'b0;
        stop_b  = 1'b0;
        wr_b    = 1'b0;
    endtask

    // Monitor: one expectation per clock, sampled 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.ca) begin
                    chk({e.tag, ".busy"}, 8'(busy_a), 8'(e.busy));
                    chk({e.tag, ".done"}, 8'(done_a), 8'(e.done));
                    chk({e.tag, ".step"}, 8'(step_a), 8'(e.step));
                    chk({e.tag, ".spk"},  8'(spk_a),  8'(e.spk));
                end
                if (e.cb) begin
                    chk({e.tag, ".spkb"}, 8'(spk_b), 8'(e.spkb));
                end
            end
        end
    end

    initial begin
        bit [2:0] s;
        rst_n   = 1'b0;
        start_a = 1'b0; stop_a = 1'b0; loop_a = 1'b0; wr_a = 1'b0;
        len_a   = 4'd0; wa_a = 3'd0; wi_a = 9'd0;
        start_b = 1'b0; stop_b = 1'b0; loop_b = 1'b0; wr_b = 1'b0;
        len_b   = 4'd0; wa_b = 3'd0; wi_b = 9'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) cyc(ea("reset", 0, 0, 3'd0, 0));

        wr_a = 1'b1; wa_a = 3'd0; wi_a = 9'd2;
        cyc(ea("wr0", 0, 0, 3'd0, 0));
        wr_a = 1'b1; wa_a = 3'd1; wi_a = 9'd0;
        cyc(ea("wr1", 0, 0, 3'd0, 0));
        wr_a = 1'b1; wa_a = 3'd2; wi_a = 9'd3;
        cyc(ea("wr2", 0, 0, 3'd0, 0));

        // Tune {2,0,3}: only the last clock of step 2 reaches acc=9
        len_a = 4'd3; loop_a = 1'b0; start_a = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 5) begin
                start_a = 1'b1;
                len_a   = 4'd1;
            end
            cyc(ea($sformatf("play%0d", k), k < 12, k == 12,
                   (k < 12) ? 3'(k / 4) : 3'd0, k == 11));
        end

        // Loop {5,0}: step 0 is high on its last two clocks (acc 10,15)
        wr_a = 1'b1; wa_a = 3'd0; wi_a = 9'd5;
        cyc(ea("wr0b", 0, 0, 3'd0, 0));
        wr_a = 1'b1; wa_a = 3'd1; wi_a = 9'd0;
        cyc(ea("wr1b", 0, 0, 3'd0, 0));
        len_a = 4'd2; loop_a = 1'b1; start_a = 1'b1;
        for (int k = 0; k < 18; k++) begin
            s = 3'((k / 4) % 2);
            cyc(ea($sformatf("loop%0d", k), 1, 0, s,
                   (s == 3'd0) && ((k % 4) >= 2)));
        end
        stop_a = 1'b1;
        cyc(ea("stop", 0, 0, 3'd0, 0));
        loop_a = 1'b0;
        cyc(ea("stop_idle0", 0, 0, 3'd0, 0));
        cyc(ea("stop_idle1", 0, 0, 3'd0, 0));

        len_a = 4'd3; start_a = 1'b1; stop_a = 1'b1;
        cyc(ea("startstop0", 0, 0, 3'd0, 0));
        cyc(ea("startstop1", 0, 0, 3'd0, 0));

        len_a = 4'd0; start_a = 1'b1;
        cyc(ea("len0", 0, 1, 3'd0, 0));
        cyc(ea("len0_after", 0, 0, 3'd0, 0));

        len_a = 4'd3; start_a = 1'b1;
        cyc(ea("arst_k0", 1, 0, 3'd0, 0));
        cyc(ea("arst_k1", 1, 0, 3'd0, 0));
        cyc(ea("arst_k2", 1, 0, 3'd0, 1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 8'(busy_a), 8'd0);
        chk("arst.spk",  8'(spk_a),  8'd0);
        chk("arst.step", 8'(step_a), 8'd0);
        chk("arst.done", 8'(done_a), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(ea("post_arst0", 0, 0, 3'd0, 0));
        cyc(ea("post_arst1", 0, 0, 3'd0, 0));

        // Slow tempo: inc 1 gives a 16-clock period, inc 4 a 4-clock one
        wr_b = 1'b1; wa_b = 3'd0; wi_b = 9'd1;
        cyc(eb("wrb1", 0));
        len_b = 4'd1; start_b = 1'b1;
        for (int k = 0; k < 32; k++)
            cyc(eb($sformatf("nco1_%0d", k), (k % 16) >= 8));
        stop_b = 1'b1;
        cyc(eb("stopb1", 0));
        wr_b = 1'b1; wa_b = 3'd0; wi_b = 9'd4;
        cyc(eb("wrb4", 0));
        start_b = 1'b1;
        for (int k = 0; k < 16; k++)
            cyc(eb($sformatf("nco4_%0d", k), (k % 4) >= 2));
        stop_b = 1'b1;
        cyc(eb("stopb4", 0));

        repeat (2) @(negedge clk);
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
